// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the IF/MEM memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Default data/address width of the core.
  localparam int XLEN_DEFAULT = 32;

  // Read data returned when the watchdog aborts a hung access.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Which requester owns the memory port.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: picks which pending requester (fetch or data) gets the next memory access.
// Latency: combinational.
// Backpressure: none; the losing requester stays pending and is re-arbitrated next pass.
// Build option: MEM_ARB_RR_EN selects round-robin on contention, otherwise data wins.
module mem_arb_pick (
  input  logic if_req_i,
  input  logic dm_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant_i,
`endif
  output logic gnt_o
);
  import mem_arb_pkg::*;

  // Grant selection; a lone requester always wins, contention resolved below.
  always_comb begin
    gnt_o = GNT_I;
    if (dm_req_i && !if_req_i) begin
      gnt_o = GNT_D;
    end else if (dm_req_i && if_req_i) begin
`ifdef MEM_ARB_RR_EN
      // Favour whichever side was not served on the previous access.
      gnt_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
`else
      // Data side wins so loads/stores never starve behind fetches.
      gnt_o = GNT_D;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and load/store, with a hung-memory watchdog.
// Latency: req seen in IDLE at c -> mem_req at c+1 -> mem_ack at k -> ready pulse at k+1 -> IDLE at k+2.
// Backpressure: requesters hold req until their ready pulse (stall high meanwhile); memory may wait-state via mem_ack.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (default: fixed data-over-fetch priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_be,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ready,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            err
);

  // Watchdog counter wide enough for the largest legal TIMEOUT (255).
  localparam int            CW       = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            wd_expire;
  logic [XLEN-1:0] rsp_dat;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic [XLEN-1:0] if_rdata_q, dm_rdata_q;
  logic            if_ready_q, dm_ready_q, err_q;
  logic            gnt;
`ifdef MEM_ARB_RR_EN
  logic            last_grant_q;
`endif

  mem_arb_pick u_pick (
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
`ifdef MEM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_o        (gnt)
  );

  // Watchdog next count, expiry on the TIMEOUT-th ack-less cycle, and response data mux.
  always_comb begin
    wd_cnt_d  = wd_cnt_q + CW'(1);
    wd_expire = ~mem_ack & (wd_cnt_q == CNT_LAST);
    rsp_dat   = mem_ack ? mem_rdata : XLEN'(TIMEOUT_DATA);
  end

  // Access sequencer: arbitration, command register, completion/abort and ready pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      wd_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'h0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= GNT_I;
`endif
    end else begin
      // Ready is a single-cycle pulse; only the SERVE exit raises it.
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || dm_req) begin
            mem_req_q <= 1'b1;
            if (gnt == GNT_D) begin
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
              mem_be_q    <= dm_be;
              state_q     <= SERVE_D;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= 4'hF;
              state_q     <= SERVE_I;
            end
`ifdef MEM_ARB_RR_EN
            last_grant_q <= gnt;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          // An ack on the expiry cycle counts as a normal completion.
          if (mem_ack || wd_expire) begin
            mem_req_q <= 1'b0;
            wd_cnt_q  <= '0;
            state_q   <= RESP;
            if (state_q == SERVE_I) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= rsp_dat;
            end else begin
              dm_ready_q <= 1'b1;
              // Stores leave the previous load data in place.
              if (!mem_we_q) begin
                dm_rdata_q <= rsp_dat;
              end
            end
            if (!mem_ack) begin
              err_q <= 1'b1;
            end
          end else begin
            wd_cnt_q <= wd_cnt_d;
          end
        end
        RESP: begin
          // One idle edge lets the served requester drop or advance its request.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;
  assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with a wait-state memory responder and a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            if_req = 1'b0;
  logic [31:0]     if_addr = '0;
  logic [31:0]     if_rdata;
  logic            if_ready;
  logic            dm_req = 1'b0;
  logic            dm_we = 1'b0;
  logic [31:0]     dm_addr = '0;
  logic [31:0]     dm_wdata = '0;
  logic [3:0]      dm_be = 4'h0;
  logic [31:0]     dm_rdata;
  logic            dm_ready;
  logic            stall;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;
  logic [31:0]     mem_rdata = '0;
  logic            mem_ack = 1'b0;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Memory responder controls.
  int          ack_wait  = 0;
  bit          ack_never = 1'b0;
  bit          rand_wait = 1'b0;
  bit          ovr_en    = 1'b0;
  logic [31:0] ovr_dat   = '0;
  int          wcnt      = 0;
  int          cur_wait  = 0;

  // Model of which side was served last (0 = fetch, 1 = data); reset value is fetch.
  bit last_is_d = 1'b0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;
  cmd_t log_q[$];

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clock = ~clock;

  // Memory contents as a pure function of address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  // Wait-state memory: acks after cur_wait cycles of mem_req, logging the command it saw.
  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      if (wcnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : ack_wait;
      if (!ack_never && wcnt == cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = ovr_en ? ovr_dat : rd_fn(mem_addr);
        log_q.push_back({mem_we, mem_addr, mem_wdata, mem_be});
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      wcnt++;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      wcnt      = 0;
    end
  end

  task automatic run_dm(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        output bit got, output int n, output logic [31:0] rd);
    got = 1'b0; n = 0; rd = '0;
    @(negedge clock);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
    while (!got && n < 300) begin
      @(negedge clock); n++;
      if (dm_ready === 1'b1) begin got = 1'b1; rd = dm_rdata; end
    end
    dm_req = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] a, output bit got, output int n, output logic [31:0] rd);
    got = 1'b0; n = 0; rd = '0;
    @(negedge clock);
    if_req = 1'b1; if_addr = a;
    while (!got && n < 300) begin
      @(negedge clock); n++;
      if (if_ready === 1'b1) begin got = 1'b1; rd = if_rdata; end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({mem_req, mem_we, if_ready, dm_ready, err, stall} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, mem_we, if_ready, dm_ready, err, stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata);
    end
    // Reset in the middle of a data access.
    reset = 1'b1; ack_never = 1'b1;
    @(negedge clock);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    @(negedge clock);
    checks++;
    if ({mem_req, stall} !== 2'b11) begin
      errors++; $display("FAIL reset_pre_serve got mem_req,stall=%b exp=11", {mem_req, stall});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({mem_req, dm_ready, err} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_serve got mem_req,dm_ready,err=%b exp=000", {mem_req, dm_ready, err});
    end
    dm_req = 1'b0;
    @(negedge clock);
    reset = 1'b1; ack_never = 1'b0; last_is_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({mem_req, dm_ready, if_ready} !== 3'b000) begin
        errors++; $display("FAIL reset_after_idle cyc=%0d got=%b exp=000", i, {mem_req, dm_ready, if_ready});
      end
    end
    log_q.delete();
  endtask

  task automatic test_single_fetch();
    bit got; int n; logic [31:0] rd;
    log_q.delete();
    ovr_en = 1'b1; ovr_dat = 32'h0020_0113; ack_wait = 2;
    run_if(32'h0000_0004, got, n, rd);
    checks++;
    if (!got || n !== 4) begin
      errors++; $display("FAIL fetch_latency got=%0d (seen=%0d) exp=4", n, got);
    end
    checks++;
    if (rd !== 32'h0020_0113) begin
      errors++; $display("FAIL fetch_rdata got=%h exp=00200113", rd);
    end
    checks++;
    if (log_q.size() !== 1 || log_q[0].we !== 1'b0 || log_q[0].be !== 4'hF || log_q[0].addr !== 32'h4) begin
      errors++; $display("FAIL fetch_cmd got n=%0d exp n=1 we=0 be=f addr=4", log_q.size());
    end
    @(negedge clock);
    checks++;
    if ({if_ready, stall} !== 2'b00) begin
      errors++; $display("FAIL fetch_after got if_ready,stall=%b exp=00", {if_ready, stall});
    end
    ovr_en = 1'b0; ack_wait = 0; last_is_d = 1'b0;
  endtask

  task automatic test_store();
    bit got; int n; logic [31:0] rd; logic [31:0] prev;
    ack_wait = 1;
    run_dm(1'b0, 32'h300, 32'h0, 4'h0, got, n, rd);
    checks++;
    if (!got || rd !== rd_fn(32'h300)) begin
      errors++; $display("FAIL load_rdata got=%h exp=%h", rd, rd_fn(32'h300));
    end
    prev = rd;
    log_q.delete();
    run_dm(1'b1, 32'h200, 32'hCAFE_F00D, 4'b0011, got, n, rd);
    checks++;
    if (!got || n !== 3) begin
      errors++; $display("FAIL store_ready got n=%0d seen=%0d exp=3", n, got);
    end
    checks++;
    if (rd !== prev) begin
      errors++; $display("FAIL store_rdata_kept got=%h exp=%h", rd, prev);
    end
    checks++;
    if (log_q.size() !== 1 || log_q[0] !== {1'b1, 32'h200, 32'hCAFE_F00D, 4'b0011}) begin
      errors++; $display("FAIL store_cmd got n=%0d exp we=1 addr=200 wdata=cafef00d be=3", log_q.size());
    end
    ack_wait = 0; last_is_d = 1'b1;
  endtask

  task automatic test_both_pending();
    int ni, nd; bit both; bit first_d; logic stall_first; logic [31:0] rd_i, rd_d;
`ifdef MEM_ARB_RR_EN
    first_d = !last_is_d;
`else
    first_d = 1'b1;
`endif
    ack_wait = 0; ni = -1; nd = -1; both = 1'b0; stall_first = 1'b0; rd_i = '0; rd_d = '0;
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h8; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int n = 1; n <= 40 && (ni < 0 || nd < 0); n++) begin
      @(negedge clock);
      if (if_ready === 1'b1 && dm_ready === 1'b1) both = 1'b1;
      if ((if_ready === 1'b1 || dm_ready === 1'b1) && ni < 0 && nd < 0) stall_first = stall;
      if (if_ready === 1'b1 && ni < 0) begin ni = n; rd_i = if_rdata; if_req = 1'b0; end
      if (dm_ready === 1'b1 && nd < 0) begin nd = n; rd_d = dm_rdata; dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    checks++;
    if (both) begin
      errors++; $display("FAIL both_ready_overlap got=1 exp=0");
    end
    checks++;
    if (first_d ? (nd !== 2 || ni !== 5) : (ni !== 2 || nd !== 5)) begin
      errors++; $display("FAIL both_order got i@%0d d@%0d exp first_d=%0d at 2, other at 5", ni, nd, first_d);
    end
    checks++;
    if (stall_first !== 1'b1) begin
      errors++; $display("FAIL both_loser_stall got=%b exp=1", stall_first);
    end
    checks++;
    if (rd_i !== rd_fn(32'h8) || rd_d !== rd_fn(32'h100)) begin
      errors++; $display("FAIL both_rdata got %h/%h exp %h/%h", rd_i, rd_d, rd_fn(32'h8), rd_fn(32'h100));
    end
    last_is_d = !first_d;
  endtask

  task automatic test_timeout();
    bit got; int n; logic [31:0] rd;
    ack_never = 1'b1;
    run_dm(1'b0, 32'h180, 32'h0, 4'h0, got, n, rd);
    checks++;
    if (!got || n !== TO + 1) begin
      errors++; $display("FAIL timeout_latency got=%0d seen=%0d exp=%0d", n, got, TO + 1);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL timeout_rdata got=%h exp=deadbeef", rd);
    end
    checks++;
    if ({err, mem_req} !== 2'b10) begin
      errors++; $display("FAIL timeout_err got err,mem_req=%b exp=10", {err, mem_req});
    end
    ack_never = 1'b0;
    run_if(32'h10, got, n, rd);
    checks++;
    if (!got || rd !== rd_fn(32'h10) || err !== 1'b1) begin
      errors++; $display("FAIL err_sticky_fetch got rd=%h err=%b exp rd=%h err=1", rd, err, rd_fn(32'h10));
    end
    run_dm(1'b1, 32'h20, 32'h1, 4'h1, got, n, rd);
    checks++;
    if (!got || err !== 1'b1) begin
      errors++; $display("FAIL err_sticky_store got seen=%0d err=%b exp seen=1 err=1", got, err);
    end
    last_is_d = 1'b1;
  endtask

  task automatic test_ack_at_timeout();
    bit got; int n; logic [31:0] rd;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1; last_is_d = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_cleared got=%b exp=0", err);
    end
    ack_wait = TO - 1;
    run_dm(1'b0, 32'h1C0, 32'h0, 4'h0, got, n, rd);
    checks++;
    if (!got || n !== TO + 1 || rd !== rd_fn(32'h1C0)) begin
      errors++; $display("FAIL ack_at_timeout got n=%0d rd=%h exp n=%0d rd=%h", n, rd, TO + 1, rd_fn(32'h1C0));
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL ack_at_timeout_err got=%b exp=0", err);
    end
    ack_wait = 0; last_is_d = 1'b1;
  endtask

  task automatic test_random();
    rand_wait = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int sel, served, want; bit di, dd, first_d, done_i, done_d, is_d, exp_d;
      logic [31:0] ia, da, dwd, prev; logic dwe; logic [3:0] dbe; cmd_t c, ec;
      sel = int'($urandom_range(0, 2));
      di = (sel != 1); dd = (sel != 0);
      ia = $urandom; da = $urandom; dwd = $urandom;
      dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(0, 15));
`ifdef MEM_ARB_RR_EN
      first_d = (di && dd) ? !last_is_d : dd;
`else
      first_d = dd;
`endif
      want = int'(di) + int'(dd); served = 0; done_i = 1'b0; done_d = 1'b0;
      log_q.delete();
      @(negedge clock);
      prev = dm_rdata;
      if_req = di; if_addr = ia; dm_req = dd; dm_we = dwe; dm_addr = da; dm_wdata = dwd; dm_be = dbe;
      for (int t = 0; t < 60 && served < want; t++) begin
        @(negedge clock);
        if (if_ready === 1'b1 && dm_ready === 1'b1) begin
          checks++; errors++; $display("FAIL rnd_overlap round=%0d both ready", r);
        end
        if (if_ready === 1'b1 || dm_ready === 1'b1) begin
          is_d = (dm_ready === 1'b1);
          exp_d = (served == 0) ? first_d : !first_d;
          checks++;
          if (is_d !== exp_d || mem_req !== 1'b0) begin
            errors++; $display("FAIL rnd_order round=%0d got d=%0d mem_req=%b exp d=%0d mem_req=0", r, is_d, mem_req, exp_d);
          end
          if (is_d) begin
            ec = {dwe, da, dwe ? dwd : 32'h0, dbe};
            checks++;
            if (dm_rdata !== (dwe ? prev : rd_fn(da))) begin
              errors++; $display("FAIL rnd_dm_rdata round=%0d got=%h exp=%h", r, dm_rdata, dwe ? prev : rd_fn(da));
            end
            done_d = 1'b1; dm_req = 1'b0;
          end else begin
            ec = {1'b0, ia, 32'h0, 4'hF};
            checks++;
            if (if_rdata !== rd_fn(ia)) begin
              errors++; $display("FAIL rnd_if_rdata round=%0d got=%h exp=%h", r, if_rdata, rd_fn(ia));
            end
            done_i = 1'b1; if_req = 1'b0;
          end
          c = (log_q.size() > 0) ? log_q.pop_front() : '0;
          if (!ec.we) c.wdata = 32'h0;
          checks++;
          if (c !== ec) begin
            errors++; $display("FAIL rnd_cmd round=%0d got=%h exp=%h", r, c, ec);
          end
          last_is_d = is_d;
          served++;
        end
      end
      if_req = 1'b0; dm_req = 1'b0;
      checks++;
      if (served !== want || done_i !== di || done_d !== dd) begin
        errors++; $display("FAIL rnd_complete round=%0d got served=%0d exp=%0d", r, served, want);
      end
    end
    rand_wait = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_both_pending();
    test_timeout();
    test_ack_at_timeout();
    test_random();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores) of the 5-stage RISC-V core.
- Sequences every access through a small FSM, drives pipeline stall, and returns read data with a one-cycle ready pulse.
- Guards against a hung memory with a watchdog counter.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 16, maximum SERVE cycles without mem_ack before the access is aborted; legal range 2..255.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  XLEN  fetch address
- if_rdata  out  XLEN  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held with dm_* payload until dm_ready
- dm_we  in  1  1=store, 0=load
- dm_addr  in  XLEN  data address
- dm_wdata  in  XLEN  store data
- dm_be  in  4  store byte enables
- dm_rdata  out  XLEN  load data, valid when dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data
- stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready); combinational
- mem_req  out  1  memory request, registered
- mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/4  registered memory command
- mem_rdata  in  XLEN  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion; 0 or more wait cycles after mem_req rises
- err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - mem_req, mem_we, if_ready, dm_ready, err = 0.
  - mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata = 0.
  - Watchdog counter = 0.
  - Reset mid-access abandons the access; no ready pulse is issued.
- FSM states: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE:
  - Choose requester (default: dm wins over if).
  - Register the command into the mem_* outputs and set mem_req=1; go to SERVE_D or SERVE_I.
  - Fetch sets mem_we=0, mem_be=4'hF.
  - With no request, stay in IDLE.
- SERVE_x, normal completion:
  - Hold mem_req and the command until mem_ack=1.
  - On mem_ack: set mem_req=0 and go to RESP.
  - On a load or fetch, capture mem_rdata into x_rdata.
  - On a store, dm_rdata holds its previous value.
- SERVE_x, watchdog:
  - Counter increments each SERVE cycle without mem_ack.
  - On the TIMEOUT-th such cycle: go to RESP, set x_rdata=32'hDEAD_BEEF (loads/fetch), set err=1 (sticky until reset), drop mem_req.
  - mem_ack in the same cycle as the timeout wins: normal completion, err unchanged.
  - Counter clears on leaving SERVE.
- RESP:
  - The selected x_ready=1 for exactly this cycle; no new command is issued.
  - Next state IDLE.
  - Gives requesters one edge to drop or advance req.
- Latency: request seen in IDLE at cycle c → mem_req in c+1 → mem_ack at cycle k≥c+1 → ready at k+1 → IDLE at k+2.
  - Zero-wait memory: back-to-back accesses every 3 cycles.
- Both requesters pending: exactly one is served per pass. The loser stays pending, so stall remains 1.
- if_ready and dm_ready are never high in the same cycle. mem_req is never high in RESP or IDLE.
- Requester dropping req while in SERVE is a protocol violation. The access still completes and the pulse is still generated.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset = IF) gives priority to the requester not served last when both are pending; a single pending requester always wins.
- Undefined: fixed priority, dm over if. No last_grant register is present.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, SERVE_I, SERVE_D, RESP);
  - the grant enum (GNT_I, GNT_D);
  - the constant TIMEOUT_DATA = 32'hDEAD_BEEF;
  - the default XLEN.
- Sub-module mem_arb_pick: combinational grant selection from if_req, dm_req and last_grant, with the MEM_ARB_RR_EN variant inside. The FSM, watchdog and datapath stay in the top.

Test Plan:
- Reset mid-SERVE_D with mem_req=1 → next cycle mem_req=0, state IDLE, no dm_ready pulse, err=0.
- Single fetch with if_addr=0x0000_0004, mem_ack after 2 waits carrying mem_rdata=0x0020_0113 → if_rdata=0x0020_0113 and if_ready pulse exactly 1 cycle after ack; stall=0 the following cycle.
- if_req and dm_req (load, 0x100) raised together, zero-wait memory:
  - without MEM_ARB_RR_EN: data served first, then fetch, ready pulses 3 cycles apart;
  - with MEM_ARB_RR_EN and last_grant=D: fetch served first.
- Store with dm_addr=0x200, dm_wdata=0xCAFE_F00D, dm_be=4'b0011 → mem_we=1, mem_be=4'b0011, payload correct; dm_rdata unchanged; dm_ready pulse.
- mem_ack never asserted on a load, TIMEOUT=16 → on the 16th SERVE cycle: dm_rdata=0xDEAD_BEEF, dm_ready pulse, err=1 and remains 1 across later successful accesses.
- mem_ack arrives on exactly the 16th SERVE cycle → normal data returned, err stays 0.
